pool_sched: RTL and testbench

Frame-level round-robin scheduler that shares one `pool_relu` instance among `N_CH` channel producers, typically the conv-stage output channels. It grants one channel for a whole `H`×`W` feature map and forwards that channel's pixels into the pool datapath. It holds the pool cleared between frames and tags each pooled/ReLU'd result with its channel index. It sits between the conv channel outputs and the dense-layer input buffer.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/pool_sched_rr_arbiter.sv | 42 ++++
 rtl/pool_sched.sv | 186 ++++++++++++++++++
 tb/tb_pool_sched.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN pipeline blocks.
//   pool_sched_state_t : frame scheduler states (IDLE / STREAM / DRAIN)
//   clog2_min1()       : index width that never collapses to zero bits
//   CNN_IN_D_W, CNN_W, CNN_H : default pixel width and frame size, shared
//                        with pool_relu so both sides agree by default
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_IN_D_W = 32;
    localparam int CNN_W      = 26;
    localparam int CNN_H      = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } pool_sched_state_t;

    // A one-entry index still needs a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches upward from last+1,
// wrapping, and returns the first active requester.
//   req        in  N            request vector
//   last       in  clog2_min1(N) index of the previously served requester
//   gnt_onehot out N            one-hot winner (all zero when req==0)
//   gnt_idx    out clog2_min1(N) binary index of the winner
// ---------------------------------------------------------------------------
module rr_arbiter
    import cnn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   last,
    output logic [N-1:0]               gnt_onehot,
    output logic [clog2_min1(N)-1:0]   gnt_idx
);

    localparam int IW = clog2_min1(N);

    // last < N and i <= N, so a single subtraction is enough to wrap.
    always_comb begin
        logic w_found;
        int   w_cand;
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        for (int i = 1; i <= N; i++) begin
            w_cand = int'(last) + i;
            if (w_cand >= N) w_cand = w_cand - N;
            if (!w_found && req[w_cand]) begin
                w_found            = 1'b1;
                gnt_onehot[w_cand] = 1'b1;
                gnt_idx            = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/pool_sched.sv
// ---------------------------------------------------------------------------
// pool_sched
// Frame-level round-robin scheduler sharing one pool_relu among N_CH
// channel producers. A granted channel owns the pool for a whole W x H
// frame; results coming back are registered and tagged with the channel.
//
// Optional feature: define POOL_SCHED_TIMEOUT_EN to enable a DRAIN
// watchdog (TO_CYC cycles) that raises a sticky err and forces IDLE.
//
// Ports
//   clk, clr_n          clock, async active-low reset
//   req[N_CH]           per-channel frame request (level)
//   in_valid/in_data    per-channel pixel stream (channel k at k*In_d_W)
//   grant, in_ready     one-hot owner / per-channel ready
//   pool_clr, pool_in_* drive pool_relu
//   pool_out_*          from pool_relu
//   out_valid/data/ch/last  registered, tagged results
//   busy, err           state != IDLE / sticky watchdog flag
// ---------------------------------------------------------------------------
module pool_sched
    import cnn_pkg::*;
#(
    parameter int In_d_W = CNN_IN_D_W,
    parameter int W      = CNN_W,
    parameter int H      = CNN_H,
    parameter int N_CH   = 4,
    parameter int TO_CYC = 64
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic [N_CH-1:0]             req,
    input  logic [N_CH-1:0]             in_valid,
    input  logic [N_CH*In_d_W-1:0]      in_data,
    output logic [N_CH-1:0]             grant,
    output logic [N_CH-1:0]             in_ready,
    output logic                        pool_clr,
    output logic                        pool_in_valid,
    output logic [In_d_W-1:0]           pool_in_data,
    input  logic                        pool_out_valid,
    input  logic [In_d_W-1:0]           pool_out_data,
    output logic                        out_valid,
    output logic [In_d_W-1:0]           out_data,
    output logic [clog2_min1(N_CH)-1:0] out_ch,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err
);

    localparam int IW        = clog2_min1(N_CH);
    localparam int PIX_TOTAL = W * H;
    localparam int OUT_TOTAL = (W / 2) * (H / 2);
    localparam int PIX_W     = $clog2(W * H + 1);
    localparam int OUT_W     = $clog2(W * H / 4 + 1);

    pool_sched_state_t r_state, w_nextState;

    logic [N_CH-1:0]  r_grant;
    logic [IW-1:0]    r_gidx;
    logic [IW-1:0]    r_last;
    logic [PIX_W-1:0] r_pixCnt;
    logic [OUT_W-1:0] r_outCnt;
    logic [N_CH-1:0]  w_arbOnehot;
    logic [IW-1:0]    w_arbIdx;
    logic             w_pixAccept;
    logic             w_outAccept;
    logic             w_frameDone;
    logic             w_timeout;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req        (req),
        .last       (r_last),
        .gnt_onehot (w_arbOnehot),
        .gnt_idx    (w_arbIdx)
    );

    // Results arriving in IDLE belong to no frame and are dropped.
    assign w_pixAccept = (r_state == ST_STREAM) && in_valid[r_gidx];
    assign w_outAccept = (r_state != ST_IDLE) && pool_out_valid;
    assign w_frameDone = w_outAccept && (r_outCnt == OUT_W'(OUT_TOTAL - 1));

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYC + 1);
    logic [TOW-1:0] r_drainCnt;
    logic           r_err;

    assign w_timeout = (r_state == ST_DRAIN) && !w_frameDone &&
                       (r_drainCnt == TOW'(TO_CYC - 1));

    // Watchdog counts only DRAIN cycles; err holds until reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_drainCnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_DRAIN) r_drainCnt <= r_drainCnt + 1'b1;
            else                     r_drainCnt <= '0;
            if (w_timeout)           r_err      <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_nextState   = r_state;
        pool_clr      = 1'b0;
        pool_in_valid = 1'b0;
        pool_in_data  = '0;
        in_ready      = '0;
        busy          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                pool_clr = 1'b1;
                busy     = 1'b0;
                if (|req) w_nextState = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready      = r_grant;
                pool_in_valid = w_pixAccept;
                pool_in_data  = in_data[int'(r_gidx)*In_d_W +: In_d_W];
                if (w_frameDone)
                    w_nextState = ST_IDLE;
                else if (w_pixAccept && r_pixCnt == PIX_W'(PIX_TOTAL - 1))
                    w_nextState = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_frameDone || w_timeout) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Grant and counters are loaded together on leaving IDLE; leaving a
    // frame (normally or by watchdog) releases the grant and records the
    // served channel for the next round-robin search.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_last   <= IW'(N_CH - 1);
            r_pixCnt <= '0;
            r_outCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE) begin
                if (|req) begin
                    r_grant  <= w_arbOnehot;
                    r_gidx   <= w_arbIdx;
                    r_pixCnt <= '0;
                    r_outCnt <= '0;
                end
            end else begin
                if (w_pixAccept) r_pixCnt <= r_pixCnt + 1'b1;
                if (w_outAccept) r_outCnt <= r_outCnt + 1'b1;
                if (w_nextState == ST_IDLE) begin
                    r_grant <= '0;
                    r_last  <= r_gidx;
                end
            end
        end
    end

    // Output stage: one register between pool_relu and the consumer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= w_outAccept;
            out_last  <= w_frameDone;
            if (w_outAccept) begin
                out_data <= pool_out_data;
                out_ch   <= r_gidx;
            end
        end
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_pool_sched.sv
// ---------------------------------------------------------------------------
// tb_pool_sched
// Directed bench for pool_sched with W=H=4, N_CH=2, TO_CYC=8 and a small
// behavioural 2x2 max-pool + ReLU standing in for pool_relu.
// Build with POOL_SCHED_TIMEOUT_EN to include the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_pool_sched;

    logic        clk;
    logic        clr_n;
    logic [1:0]  req;
    logic [1:0]  inValid;
    logic [63:0] inData;
    logic [1:0]  grant;
    logic [1:0]  in_ready;
    logic        pool_clr;
    logic        pool_in_valid;
    logic [31:0] pool_in_data;
    logic        pool_out_valid;
    logic [31:0] pool_out_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [0:0]  out_ch;
    logic        out_last;
    logic        busy;
    logic        err;

    logic        forceNoOut;
    int          nChecks;
    int          nErrors;

    typedef struct {
        logic [31:0] d;
        logic [0:0]  ch;
        logic        last;
    } res_t;
    res_t q[$];

    pool_sched #(
        .In_d_W (32),
        .W      (4),
        .H      (4),
        .N_CH   (2),
        .TO_CYC (8)
    ) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .req            (req),
        .in_valid       (inValid),
        .in_data        (inData),
        .grant          (grant),
        .in_ready       (in_ready),
        .pool_clr       (pool_clr),
        .pool_in_valid  (pool_in_valid),
        .pool_in_data   (pool_in_data),
        .pool_out_valid (pool_out_valid),
        .pool_out_data  (pool_out_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ch         (out_ch),
        .out_last       (out_last),
        .busy           (busy),
        .err            (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural pool_relu: raster 4x4 in, one ReLU'd 2x2 max out one
    // cycle after the bottom-right pixel of each window.
    logic signed [31:0] mWin [2];
    logic               mOutValid;
    logic [31:0]        mOutData;
    int                 mCol;
    int                 mRow;

    always @(posedge clk) begin : poolModel
        int k;
        logic signed [31:0] d;
        logic signed [31:0] m;
        if (pool_clr) begin
            mCol      <= 0;
            mRow      <= 0;
            mOutValid <= 1'b0;
        end else begin
            mOutValid <= 1'b0;
            if (pool_in_valid) begin
                d = pool_in_data;
                k = mCol / 2;
                if (mRow % 2 == 0 && mCol % 2 == 0) begin
                    mWin[k] <= d;
                end else begin
                    m = (mWin[k] > d) ? mWin[k] : d;
                    mWin[k] <= m;
                    if (mRow % 2 == 1 && mCol % 2 == 1) begin
                        mOutValid <= 1'b1;
                        mOutData  <= (m < 0) ? 32'd0 : m;
                    end
                end
                if (mCol == 3) begin
                    mCol <= 0;
                    mRow <= (mRow == 3) ? 0 : mRow + 1;
                end else begin
                    mCol <= mCol + 1;
                end
            end
        end
    end

    assign pool_out_valid = mOutValid & ~forceNoOut;
    assign pool_out_data  = mOutData;

    always @(negedge clk) begin
        if (out_valid === 1'b1) q.push_back('{out_data, out_ch, out_last});
    end

    // Pixel p (0-based) of a frame: mode 0 = ramp 1..16, mode 1 = all -5.
    function automatic logic [31:0] pixVal(input int mode, input int p);
        return (mode == 0) ? 32'(p + 1) : 32'hFFFF_FFFB;
    endfunction

    // Called at a negedge; waits for grant[ch], then streams 16 pixels and
    // returns at the negedge right after the last pixel was accepted.
    task automatic applyStimulus(input int ch, input int mode, input bit gaps,
                                 input logic [1:0] reqAfter);
        int cyc = 0;
        while (grant[ch] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (grant[ch] !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL grant_wait ch%0d: grant=%b required bit set", ch, grant);
        end
        req = reqAfter;
        for (int p = 0; p < 16; p++) begin
            if (gaps) begin
                inValid[ch] = 1'b0;
                @(negedge clk);
            end
            inValid[ch]           = 1'b1;
            inData[ch*32 +: 32]   = pixVal(mode, p);
            @(negedge clk);
        end
        inValid = 2'b00;
    endtask

    task automatic waitIdle();
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (busy !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL idle_wait: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        inData  = 64'h0000_0007_0000_0009;
        inValid = 2'b11;
        #2 clr_n = 1'b0;
        #1;
        nChecks++;
        if ({grant, in_ready, pool_clr, pool_in_valid, out_valid, out_last, busy, err}
            !== 10'b0000_1_0_0_0_0_0) begin
            nErrors++;
            $display("[TB] FAIL reset.ctrl: grant=%b rdy=%b clr=%b piv=%b ov=%b ol=%b busy=%b err=%b required 00 00 1 0 0 0 0 0",
                     grant, in_ready, pool_clr, pool_in_valid, out_valid, out_last, busy, err);
        end
        nChecks++;
        if (pool_in_data !== 32'd0 || out_data !== 32'd0 || out_ch !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL reset.data: pid=%0d od=%0d och=%0d required 0 0 0",
                     pool_in_data, out_data, out_ch);
        end
        inValid = 2'b00;
        inData  = '0;
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        q.delete();
        req = 2'b10;
        @(negedge clk);
        nChecks++;
        if (grant !== 2'b10 || in_ready !== 2'b10 || pool_clr !== 1'b0 || busy !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL single.arb: grant=%b rdy=%b clr=%b busy=%b required 10 10 0 1",
                     grant, in_ready, pool_clr, busy);
        end
        inValid[0]      = 1'b1;
        inData[31:0]    = 32'd1000;
        applyStimulus(1, 0, 1'b0, 2'b00);
        inValid = 2'b01;
        #1;
        nChecks++;
        if (busy !== 1'b1 || pool_clr !== 1'b0 || in_ready !== 2'b00 || pool_in_valid !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL single.drain: busy=%b clr=%b rdy=%b piv=%b required 1 0 00 0",
                     busy, pool_clr, in_ready, pool_in_valid);
        end
        inValid = 2'b00;
        @(negedge clk);
        nChecks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 32'd16 ||
            grant !== 2'b00 || pool_clr !== 1'b1 || busy !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL single.end: ov=%b ol=%b od=%0d grant=%b clr=%b busy=%b required 1 1 16 00 1 0",
                     out_valid, out_last, out_data, grant, pool_clr, busy);
        end
        @(negedge clk);
        nChecks++;
        if (q.size() != 4) begin
            nErrors++;
            $display("[TB] FAIL single.count: got %0d results required 4", q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            nChecks++;
            if (q[i].d !== exp[i] || q[i].ch !== 1'b1 || q[i].last !== (i == 3)) begin
                nErrors++;
                $display("[TB] FAIL single.res[%0d]: data=%0d ch=%0d last=%b required %0d 1 %b",
                         i, q[i].d, q[i].ch, q[i].last, exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_relu_negative();
        q.delete();
        req = 2'b01;
        applyStimulus(0, 1, 1'b0, 2'b00);
        waitIdle();
        @(negedge clk);
        nChecks++;
        if (q.size() != 4) begin
            nErrors++;
            $display("[TB] FAIL relu.count: got %0d results required 4", q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            nChecks++;
            if (q[i].d !== 32'd0 || q[i].ch !== 1'b0 || q[i].last !== (i == 3)) begin
                nErrors++;
                $display("[TB] FAIL relu.res[%0d]: data=%0d ch=%0d last=%b required 0 0 %b",
                         i, $signed(q[i].d), q[i].ch, q[i].last, (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        req   = 2'b11;
        clr_n = 1'b0;
        @(negedge clk);
        q.delete();
        clr_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if (grant !== 2'b01) begin
            nErrors++;
            $display("[TB] FAIL b2b.first: grant=%b required 01", grant);
        end
        applyStimulus(0, 0, 1'b0, 2'b11);
        waitIdle();
        nChecks++;
        if (pool_clr !== 1'b1 || grant !== 2'b00) begin
            nErrors++;
            $display("[TB] FAIL b2b.gap: clr=%b grant=%b required 1 00", pool_clr, grant);
        end
        @(negedge clk);
        nChecks++;
        if (grant !== 2'b10) begin
            nErrors++;
            $display("[TB] FAIL b2b.second: grant=%b required 10", grant);
        end
        applyStimulus(1, 0, 1'b0, 2'b00);
        waitIdle();
        @(negedge clk);
        nChecks++;
        if (q.size() != 8) begin
            nErrors++;
            $display("[TB] FAIL b2b.count: got %0d results required 8", q.size());
        end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            nChecks++;
            if (q[i].d !== exp[i % 4] || q[i].ch !== 1'(i / 4) || q[i].last !== (i % 4 == 3)) begin
                nErrors++;
                $display("[TB] FAIL b2b.res[%0d]: data=%0d ch=%0d last=%b required %0d %0d %b",
                         i, q[i].d, q[i].ch, q[i].last, exp[i % 4], i / 4, (i % 4 == 3));
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        q.delete();
        req = 2'b10;
        applyStimulus(1, 0, 1'b1, 2'b00);
        waitIdle();
        repeat (3) @(negedge clk);
        nChecks++;
        if (q.size() != 4) begin
            nErrors++;
            $display("[TB] FAIL gaps.count: got %0d results required 4", q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            nChecks++;
            if (q[i].d !== exp[i] || q[i].ch !== 1'b1 || q[i].last !== (i == 3)) begin
                nErrors++;
                $display("[TB] FAIL gaps.res[%0d]: data=%0d ch=%0d last=%b required %0d 1 %b",
                         i, q[i].d, q[i].ch, q[i].last, exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        int cyc = 0;
        req = 2'b10;
        while (grant[1] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int p = 0; p < 7; p++) begin
            inValid[1]     = 1'b1;
            inData[63:32]  = 32'(p + 1);
            @(negedge clk);
        end
        clr_n = 1'b0;
        #1;
        nChecks++;
        if ({grant, in_ready, pool_clr, pool_in_valid, out_valid, out_last, busy}
            !== 9'b00_00_1_0_0_0_0) begin
            nErrors++;
            $display("[TB] FAIL midrst.ctrl: grant=%b rdy=%b clr=%b piv=%b ov=%b ol=%b busy=%b required 00 00 1 0 0 0 0",
                     grant, in_ready, pool_clr, pool_in_valid, out_valid, out_last, busy);
        end
        nChecks++;
        if (pool_in_data !== 32'd0 || out_data !== 32'd0 || out_ch !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL midrst.data: pid=%0d od=%0d och=%0d required 0 0 0",
                     pool_in_data, out_data, out_ch);
        end
        inValid = 2'b00;
        #1 clr_n = 1'b1;
        q.delete();
        applyStimulus(1, 0, 1'b0, 2'b00);
        waitIdle();
        @(negedge clk);
        nChecks++;
        if (q.size() != 4) begin
            nErrors++;
            $display("[TB] FAIL midrst.count: got %0d results required 4", q.size());
        end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            nChecks++;
            if (q[i].d !== exp[i] || q[i].ch !== 1'b1 || q[i].last !== (i == 3)) begin
                nErrors++;
                $display("[TB] FAIL midrst.res[%0d]: data=%0d ch=%0d last=%b required %0d 1 %b",
                         i, q[i].d, q[i].ch, q[i].last, exp[i], (i == 3));
            end
        end
    endtask

`ifdef POOL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        q.delete();
        forceNoOut = 1'b1;
        req        = 2'b01;
        applyStimulus(0, 0, 1'b0, 2'b00);
        repeat (7) @(negedge clk);
        nChecks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL timeout.early: err=%b busy=%b required 0 1", err, busy);
        end
        @(negedge clk);
        nChecks++;
        if (err !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || pool_clr !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL timeout.fire: err=%b busy=%b grant=%b clr=%b required 1 0 00 1",
                     err, busy, grant, pool_clr);
        end
        repeat (2) @(negedge clk);
        nChecks++;
        if (err !== 1'b1 || q.size() != 0) begin
            nErrors++;
            $display("[TB] FAIL timeout.sticky: err=%b results=%0d required 1 0", err, q.size());
        end
        forceNoOut = 1'b0;
    endtask
`endif

    initial begin
        nChecks    = 0;
        nErrors    = 0;
        clr_n      = 1'b1;
        req        = 2'b00;
        inValid    = 2'b00;
        inData     = '0;
        forceNoOut = 1'b0;
        test_reset();
        test_single_frame();
        test_relu_negative();
        test_back_to_back();
        test_gaps();
        test_reset_mid_frame();
`ifdef POOL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
